// File: rtl/panel_pkg.sv
// panel_pkg: shared mode and colour encodings for the front-panel controller
// No ports; imported by led_panel_ctrl.
package panel_pkg;
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_COUNT = 2'd2,
        MODE_ECHO  = 2'd3
    } mode_e;

    localparam logic [1:0] COL_R = 2'd0;
    localparam logic [1:0] COL_G = 2'd1;
    localparam logic [1:0] COL_B = 2'd2;

    function automatic logic [1:0] col_next(input logic [1:0] c);
        return c == COL_B ? COL_R : c + 2'd1;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise and debounce one button, pulse once per accepted press
// Ports:
//   CLK     - fabric clock
//   RST     - asynchronous reset, active-high
//   btn_i   - raw button, asynchronous
//   press_o - one-cycle pulse on an accepted 0->1 change
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q, stable_q, stable_d, press_q, press_d, flip;
    logic [CW-1:0] cnt_q, cnt_d;

    // the counter only runs while the synced input disagrees with the accepted state
    always_comb begin
        flip     = (sync2_q != stable_q) && (cnt_q == CW'(DEB_CYCLES - 1));
        cnt_d    = (sync2_q == stable_q || flip) ? '0 : cnt_q + CW'(1);
        stable_d = stable_q ^ flip;
        press_d  = flip && sync2_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;
endmodule

// File: rtl/led_panel_ctrl.sv
// led_panel_ctrl: button debounce, mode-selected plain LEDs and PWM colour-rotating RGB LEDs
// Ports:
//   CLK, RST         - fabric clock, asynchronous active-high reset
//   btn [N_BTN]      - raw buttons;  sw [2] - raw mode switches
//   led [N_LED]      - plain LEDs
//   rgb_r/g/b [N_RGB]- RGB LED channels
//   btn_press [N_BTN]- one-cycle accepted-press pulses
module led_panel_ctrl
    import panel_pkg::*;
#(
    parameter int N_LED       = 4,
    parameter int N_BTN       = 4,
    parameter int N_RGB       = 2,
    parameter int PWM_W       = 8,
    parameter int DEB_CYCLES  = 1000000,
    parameter int BLINK_DIV   = 50000000,
    parameter int BRIGHT_INIT = 128,
    parameter int BRIGHT_STEP = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] btn,
    input  logic [1:0]       sw,
    output logic [N_LED-1:0] led,
    output logic [N_RGB-1:0] rgb_r,
    output logic [N_RGB-1:0] rgb_g,
    output logic [N_RGB-1:0] rgb_b,
    output logic [N_BTN-1:0] btn_press
);
    localparam int               PW   = $clog2(BLINK_DIV + 1);
    localparam logic [PWM_W-1:0] BMAX = '1;
    localparam logic [PWM_W:0]   STEP = (PWM_W + 1)'(BRIGHT_STEP);

    logic [1:0]       sw1_q, sw_q, sw_prev_q;
    mode_e            mode;
    logic             chg, tick, active, lit, up, dn;
    logic [PW-1:0]    presc_q, presc_d;
    logic [N_LED-1:0] led_q, led_d, echo_mask;
    logic [PWM_W-1:0] bright_q, bright_d, pwm_q;
    logic [PWM_W:0]   bright_up;
    logic [1:0]       col_q, col_d;
    logic [N_RGB-1:0] r_q, g_q, b_q, r_d, g_d, b_d;

    for (genvar i = 0; i < N_BTN; i++) begin : g_deb
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .CLK     (CLK),
            .RST     (RST),
            .btn_i   (btn[i]),
            .press_o (btn_press[i])
        );
    end

    always_comb begin
        mode   = mode_e'(sw_q);
        chg    = sw_q != sw_prev_q;
        tick   = presc_q == PW'(BLINK_DIV - 1);
        active = mode == MODE_BLINK || mode == MODE_COUNT;
        up     = btn_press[0] && !btn_press[1];
        dn     = btn_press[1] && !btn_press[0];
        // LEDs without a matching button never toggle
        for (int i = 0; i < N_LED; i++) echo_mask[i] = (i < N_BTN) && btn_press[i % N_BTN];
        presc_d = (chg || tick) ? '0 : presc_q + PW'(1);
        led_d = (chg || mode == MODE_OFF) ? '0 :
                mode == MODE_BLINK ? (tick ? ~led_q : led_q) :
                mode == MODE_COUNT ? led_q + N_LED'(tick) :
                led_q ^ echo_mask;
        // one extra bit catches the overflow for upward saturation
        bright_up = {1'b0, bright_q} + STEP;
        bright_d = (!active || up == dn) ? bright_q :
                   up ? (bright_up > {1'b0, BMAX} ? BMAX : bright_up[PWM_W-1:0]) :
                   ({1'b0, bright_q} < STEP ? '0 : bright_q - STEP[PWM_W-1:0]);
        col_d = (chg || !active) ? COL_R : tick ? col_next(col_q) : col_q;
        lit   = mode != MODE_OFF && pwm_q < bright_q;
        r_d = '0;
        g_d = '0;
        b_d = '0;
        for (int k = 0; k < N_RGB; k++) begin
            r_d[k] = lit && ((int'(col_q) + k) % 3 == int'(COL_R));
            g_d[k] = lit && ((int'(col_q) + k) % 3 == int'(COL_G));
            b_d[k] = lit && ((int'(col_q) + k) % 3 == int'(COL_B));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sw1_q     <= '0;
            sw_q      <= '0;
            sw_prev_q <= '0;
            presc_q   <= '0;
            led_q     <= '0;
            bright_q  <= PWM_W'(BRIGHT_INIT);
            col_q     <= COL_R;
            pwm_q     <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            sw1_q     <= sw;
            sw_q      <= sw1_q;
            sw_prev_q <= sw_q;
            presc_q   <= presc_d;
            led_q     <= led_d;
            bright_q  <= bright_d;
            col_q     <= col_d;
            pwm_q     <= pwm_q + PWM_W'(1);
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    assign led   = led_q;
    assign rgb_r = r_q;
    assign rgb_g = g_q;
    assign rgb_b = b_q;
endmodule

// File: tb/tb_led_panel_ctrl.sv
// tb_led_panel_ctrl: scoreboard bench for led_panel_ctrl with small debounce/tick constants
module tb_led_panel_ctrl;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] btn = '0;
    logic [1:0] sw  = '0;
    logic [3:0] led, btn_press;
    logic [1:0] rgb_r, rgb_g, rgb_b;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [3:0] v;
    } ev_t;

    ev_t pq[$];
    ev_t sb[$];

    led_panel_ctrl #(
        .N_LED(4), .N_BTN(4), .N_RGB(2), .PWM_W(3),
        .DEB_CYCLES(4), .BLINK_DIV(8), .BRIGHT_INIT(4), .BRIGHT_STEP(1)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .btn       (btn),
        .sw        (sw),
        .led       (led),
        .rgb_r     (rgb_r),
        .rgb_g     (rgb_g),
        .rgb_b     (rgb_b),
        .btn_press (btn_press)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // press pulses are checked every cycle (absent unless queued); led only where queued
    always @(negedge CLK) begin
        ev_t        e;
        logic [3:0] m;
        m = '0;
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
            e = pq.pop_front();
            m = e.v;
        end
        chk($sformatf("btn_press@%0d", cyc), 32'(btn_press), 32'(m));
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk($sformatf("led@%0d", cyc), 32'(led), 32'(e.v));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) step();
    endtask

    function automatic void push(input int c, input logic [3:0] v);
        sb.push_back('{c, v});
    endfunction

    // raw edge at cycle X gives the pulse at X+6 (2 sync + 4 debounce)
    task automatic press(input logic [3:0] m);
        pq.push_back('{cyc + 6, m});
        btn = btn | m;
        step(8);
        btn = btn & ~m;
        step(8);
    endtask

    // high counts over 8 cycles: {r0,g0,b0,r1,g1,b1}, one nibble each
    task automatic measure(output logic [23:0] c);
        c = '0;
        repeat (8) begin
            @(negedge CLK);
            c = c + {4'(rgb_r[0]), 4'(rgb_g[0]), 4'(rgb_b[0]), 4'(rgb_r[1]), 4'(rgb_g[1]), 4'(rgb_b[1])};
        end
        step();
    endtask

    function automatic logic [7:0] tot(input logic [23:0] c);
        return {4'(c[23:20] + c[19:16] + c[15:12]), 4'(c[11:8] + c[7:4] + c[3:0])};
    endfunction

    initial begin
        #200000;
        $display("watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int          p, q;
        logic [23:0] c;
        step(3);
        chk("rst_led", 32'(led), 0);
        chk("rst_rgb", 32'({rgb_r, rgb_g, rgb_b}), 0);
        chk("rst_press", 32'(btn_press), 0);
        RST = 1'b0;
        step(2);
        // BLINK with a held button, then reset in the middle of it
        p = cyc;
        sw = 2'b01;
        btn = 4'b0100;
        pq.push_back('{p + 6, 4'b0100});
        push(p + 3, 4'h0);
        push(p + 10, 4'h0);
        push(p + 11, 4'hf);
        wait_cyc(p + 12);
        chk("pre_rst_led", 32'(led), 32'hf);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_led", 32'(led), 0);
        chk("async_rst_rgb", 32'({rgb_r, rgb_g, rgb_b}), 0);
        chk("async_rst_press", 32'(btn_press), 0);
        btn = 4'b1000;
        sw = 2'b00;
        step(2);
        RST = 1'b0;
        pq.push_back('{cyc + 6, 4'b1000});
        step(10);
        btn = '0;
        step(10);
        // 3-cycle glitch must be rejected
        btn = 4'b0100;
        step(3);
        btn = '0;
        step(10);
        // held button: exactly one pulse, none on release
        pq.push_back('{cyc + 6, 4'b0100});
        btn = 4'b0100;
        measure(c);
        chk("off_rgb", 32'(c), 0);
        step(12);
        btn = '0;
        step(10);
        // COUNT: one step per 8 cycles, wraps 15 -> 0, colour R,G,B
        p = cyc;
        sw = 2'b10;
        for (int j = 0; j <= 16; j++) begin
            push(p + 3 + 8 * j, 4'(j));
            if (j == 0 || j == 15) push(p + 10 + 8 * j, 4'(j));
        end
        wait_cyc(p + 4);
        measure(c);
        chk("count_col_r", 32'(c), 32'h400040);
        measure(c);
        chk("count_col_g", 32'(c), 32'h040004);
        measure(c);
        chk("count_col_b", 32'(c), 32'h004400);
        // led=5 with colour G, then switch to BLINK
        wait_cyc(p + 300);
        q = cyc;
        sw = 2'b01;
        push(q + 2, 4'h5);
        push(q + 3, 4'h0);
        push(q + 10, 4'h0);
        push(q + 11, 4'hf);
        push(q + 18, 4'hf);
        push(q + 19, 4'h0);
        wait_cyc(q + 4);
        measure(c);
        chk("blink_col_restart", 32'(c), 32'h400040);
        wait_cyc(q + 20);
        // brightness saturation and simultaneous press
        repeat (5) press(4'b0001);
        measure(c);
        chk("bright_sat_hi", 32'(tot(c)), 32'h77);
        repeat (8) press(4'b0010);
        measure(c);
        chk("bright_sat_lo", 32'(tot(c)), 32'h00);
        repeat (2) press(4'b0001);
        measure(c);
        chk("bright_up2", 32'(tot(c)), 32'h22);
        press(4'b0011);
        measure(c);
        chk("bright_both", 32'(tot(c)), 32'h22);
        // ECHO: toggles per press, brightness untouched, colour fixed at R
        p = cyc;
        sw = 2'b11;
        push(p + 3, 4'h0);
        step(4);
        push(cyc + 6, 4'h0);
        push(cyc + 7, 4'h2);
        press(4'b0010);
        push(cyc + 7, 4'h0);
        press(4'b0010);
        push(cyc + 7, 4'h1);
        press(4'b0001);
        measure(c);
        chk("echo_rgb", 32'(c), 32'h200020);
        step(5);
        chk("press_queue_drained", 32'(pq.size()), 0);
        chk("led_queue_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
